mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter sharing the single main-memory port between the I-cache and D-cache. Each cache keeps the same memory-side handshake it uses standalone (cache_MemRead/cache_MemWrite/cache_mem_addr out; MemDataValid/mem_read_data in). The arbiter grants one cache at a time, holds the grant for a whole block fill or one write, and routes returned data only to the granted cache. It sits between the two CACHE instances and the memory module.

## Interface
- WORDS_PER_BLOCK, 8, MemDataValid beats per block fill
- ADDR_W, 16, address width
- DATA_W, 16, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- icache_MemRead  in  1  I-cache requests a block fill
- icache_mem_addr  in  ADDR_W  I-cache memory address
- dcache_MemRead  in  1  D-cache requests a block fill
- dcache_MemWrite  in  1  D-cache requests a one-word write
- dcache_mem_addr  in  ADDR_W  D-cache memory address
- dcache_mem_write_data  in  DATA_W  D-cache write data
- MemDataValid  in  1  memory read data valid
- mem_read_data  in  DATA_W  memory read data
- mem_MemRead  out  1  read request to memory
- mem_MemWrite  out  1  write request to memory
- mem_addr  out  ADDR_W  address to memory
- mem_write_data  out  DATA_W  write data to memory
- icache_grant / dcache_grant  out  1  memory owned by that cache
- icache_MemDataValid / dcache_MemDataValid  out  1  forwarded valid
- icache_read_data / dcache_read_data  out  DATA_W  forwarded data

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. Registers: state, beat counter ($clog2(WORDS_PER_BLOCK) bits), last_grant (I or D).
- IDLE, no request: stay; all memory outputs 0.
- IDLE, requests: dcache_MemWrite -> D_WRITE if D is selected; dcache_MemRead -> D_FILL if D is selected; icache_MemRead -> I_FILL if I is selected. dcache_MemWrite beats dcache_MemRead when both are high.
- Selection: a lone requester wins. If both caches request, the cache not equal to last_grant wins (round-robin). last_grant updates on every grant.
- I_FILL/D_FILL: mem_MemRead = granted cache's MemRead. mem_addr = granted cache's address. mem_MemWrite = 0. Each MemDataValid increments the counter and is forwarded with mem_read_data to the granted cache only. On the beat where counter == WORDS_PER_BLOCK-1 and MemDataValid = 1: counter -> 0, state -> IDLE.
- The grant holds until the final beat, even if the owner drops MemRead early.
- D_WRITE: lasts exactly one cycle. mem_MemWrite = 1, mem_addr = dcache_mem_addr, mem_write_data = dcache_mem_write_data. Next state IDLE.
- Non-granted cache: grant 0, MemDataValid 0, read_data 0. mem_write_data is 0 outside D_WRITE.
- MemDataValid in IDLE or D_WRITE: ignored; not forwarded; counter unchanged.

## Timing
- Reset (rst = 0): state IDLE, counter 0, last_grant = I (so D wins the first tie). All outputs 0 immediately, without waiting for a clock edge.
- Reset asserted mid-fill or mid-write: the transfer is abandoned. Outputs go to 0 asynchronously; no beats are forwarded.
- Grant latency: a request seen in IDLE at edge N sets state at edge N. The grant and memory outputs are valid during cycle N..N+1. This costs one cycle of arbitration; requesters hold their request until granted.
- All outputs decode combinationally from state plus the current inputs. Data forwarding has zero added latency: MemDataValid/mem_read_data in cycle k appear at the owner's outputs in cycle k.
- Back-to-back: the final fill beat at edge M returns to IDLE. A pending request is granted at edge M+1, so there is at least one idle cycle between transfers.
- Memory latency between read request and first beat is not counted; only beats are counted.

## Test plan
- Reset: rst = 0 mid-I_FILL after 3 beats -> all outputs 0 at once. After release, an I request refills from beat 0 (8 beats needed).
- Single I fill: icache_MemRead = 1 with address 0x0000, memory returns 1..8 on consecutive cycles after 4 cycles -> icache_MemDataValid pulses 8 times with data 1..8, dcache outputs stay 0. Return to IDLE after beat 8.
- Tie then round-robin: both caches request reads from reset -> D fill first (8 beats), then I fill. Repeat the tie -> D wins again, because last_grant = I after the I fill.
- D write: dcache_MemWrite = 1, addr 0x0010, data 0xBEEF -> mem_MemWrite high for exactly 1 cycle with matching address and data. Back to IDLE next edge.
- Write while I filling: D write request raised at I-fill beat 2 -> D waits. It is granted on the cycle after I's 8th beat; no D forwarding happens during the I fill.
- Stray valid: MemDataValid = 1 with data 0x1234 in IDLE -> no forwarding, counter stays 0. A subsequent fill still needs 8 beats.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache.
// One owner at a time: a whole block fill or a single write, round-robin on ties.
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_MemRead,
    input  logic [ADDR_W-1:0] icache_mem_addr,
    input  logic              dcache_MemRead,
    input  logic              dcache_MemWrite,
    input  logic [ADDR_W-1:0] dcache_mem_addr,
    input  logic [DATA_W-1:0] dcache_mem_write_data,
    input  logic              MemDataValid,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              icache_grant,
    output logic              dcache_grant,
    output logic              icache_MemDataValid,
    output logic              dcache_MemDataValid,
    output logic [DATA_W-1:0] icache_read_data,
    output logic [DATA_W-1:0] dcache_read_data
);

    localparam int CNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;
    typedef enum logic {GRANT_I, GRANT_D} owner_t;

    state_t           state, state_nxt;
    owner_t           last_grant, last_grant_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    logic d_req, i_req, d_wins;

    assign d_req  = dcache_MemWrite | dcache_MemRead;
    assign i_req  = icache_MemRead;
    // On a tie the cache that did not own the port last time goes first.
    assign d_wins = d_req && (!i_req || last_grant == GRANT_I);

    // NOTE: async reset in the sensitivity list, and <= for every state register
    // so all flops update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (d_wins) begin
                    state_nxt      = dcache_MemWrite ? D_WRITE : D_FILL;
                    last_grant_nxt = GRANT_D;
                end else if (i_req) begin
                    state_nxt      = I_FILL;
                    last_grant_nxt = GRANT_I;
                end
            end
            I_FILL, D_FILL: begin
                if (MemDataValid) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            D_WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from state and live inputs; beats pass through with no delay.
    always_comb begin
        mem_MemRead         = 1'b0;
        mem_MemWrite        = 1'b0;
        mem_addr            = '0;
        mem_write_data      = '0;
        icache_grant        = 1'b0;
        dcache_grant        = 1'b0;
        icache_MemDataValid = 1'b0;
        dcache_MemDataValid = 1'b0;
        icache_read_data    = '0;
        dcache_read_data    = '0;
        case (state)
            I_FILL: begin
                icache_grant        = 1'b1;
                mem_MemRead         = icache_MemRead;
                mem_addr            = icache_mem_addr;
                icache_MemDataValid = MemDataValid;
                icache_read_data    = mem_read_data;
            end
            D_FILL: begin
                dcache_grant        = 1'b1;
                mem_MemRead         = dcache_MemRead;
                mem_addr            = dcache_mem_addr;
                dcache_MemDataValid = MemDataValid;
                dcache_read_data    = mem_read_data;
            end
            D_WRITE: begin
                dcache_grant   = 1'b1;
                mem_MemWrite   = 1'b1;
                mem_addr       = dcache_mem_addr;
                mem_write_data = dcache_mem_write_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against an ownership-level model.
module tb_mem_arbiter;

    localparam int WPB    = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_MemRead;
    logic [ADDR_W-1:0] icache_mem_addr;
    logic              dcache_MemRead;
    logic              dcache_MemWrite;
    logic [ADDR_W-1:0] dcache_mem_addr;
    logic [DATA_W-1:0] dcache_mem_write_data;
    logic              MemDataValid;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_MemRead, mem_MemWrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              icache_grant, dcache_grant;
    logic              icache_MemDataValid, dcache_MemDataValid;
    logic [DATA_W-1:0] icache_read_data, dcache_read_data;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.WORDS_PER_BLOCK(WPB), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .icache_MemRead        (icache_MemRead),
        .icache_mem_addr       (icache_mem_addr),
        .dcache_MemRead        (dcache_MemRead),
        .dcache_MemWrite       (dcache_MemWrite),
        .dcache_mem_addr       (dcache_mem_addr),
        .dcache_mem_write_data (dcache_mem_write_data),
        .MemDataValid          (MemDataValid),
        .mem_read_data         (mem_read_data),
        .mem_MemRead           (mem_MemRead),
        .mem_MemWrite          (mem_MemWrite),
        .mem_addr              (mem_addr),
        .mem_write_data        (mem_write_data),
        .icache_grant          (icache_grant),
        .dcache_grant          (dcache_grant),
        .icache_MemDataValid   (icache_MemDataValid),
        .dcache_MemDataValid   (dcache_MemDataValid),
        .icache_read_data      (icache_read_data),
        .dcache_read_data      (dcache_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: who owns the port, what kind of transfer, how many beats remain.
    typedef enum {OWN_NONE, OWN_I, OWN_D} owner_t;
    owner_t m_owner;
    owner_t m_last;
    bit     m_write;
    int     m_beats_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner      = OWN_NONE;
            m_last       = OWN_I;
            m_write      = 1'b0;
            m_beats_left = 0;
        end else if (m_owner == OWN_NONE) begin
            if ((dcache_MemRead || dcache_MemWrite) && (!icache_MemRead || m_last == OWN_I)) begin
                m_owner      = OWN_D;
                m_last       = OWN_D;
                m_write      = dcache_MemWrite;
                m_beats_left = WPB;
            end else if (icache_MemRead) begin
                m_owner      = OWN_I;
                m_last       = OWN_I;
                m_write      = 1'b0;
                m_beats_left = WPB;
            end
        end else if (m_write) begin
            m_owner = OWN_NONE;
            m_write = 1'b0;
        end else if (MemDataValid) begin
            m_beats_left--;
            if (m_beats_left == 0) m_owner = OWN_NONE;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wdata;
        e_rd    = (m_owner == OWN_I) ? icache_MemRead :
                  (m_owner == OWN_D && !m_write) ? dcache_MemRead : 1'b0;
        e_wr    = (m_owner == OWN_D) && m_write;
        e_addr  = (m_owner == OWN_I) ? 32'(icache_mem_addr) :
                  (m_owner == OWN_D) ? 32'(dcache_mem_addr) : 32'd0;
        e_wdata = e_wr ? 32'(dcache_mem_write_data) : 32'd0;
        check("mem_MemRead", 32'(mem_MemRead), 32'(e_rd));
        check("mem_MemWrite", 32'(mem_MemWrite), 32'(e_wr));
        check("mem_addr", 32'(mem_addr), e_addr);
        check("mem_write_data", 32'(mem_write_data), e_wdata);
        check("icache_grant", 32'(icache_grant), 32'(m_owner == OWN_I));
        check("dcache_grant", 32'(dcache_grant), 32'(m_owner == OWN_D));
        check("icache_valid", 32'(icache_MemDataValid), 32'(m_owner == OWN_I && MemDataValid));
        check("dcache_valid", 32'(dcache_MemDataValid),
              32'(m_owner == OWN_D && !m_write && MemDataValid));
        if (m_owner != OWN_I)
            check("icache_data_idle", 32'(icache_read_data), 32'd0);
        else if (MemDataValid)
            check("icache_data", 32'(icache_read_data), 32'(mem_read_data));
        if (m_owner != OWN_D || m_write)
            check("dcache_data_idle", 32'(dcache_read_data), 32'd0);
        else if (MemDataValid)
            check("dcache_data", 32'(dcache_read_data), 32'(mem_read_data));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n consecutive beats carrying base, base+1, ... and pin the routing.
    task automatic do_beats(input bit to_i, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            MemDataValid  = 1'b1;
            mem_read_data = DATA_W'(base + k);
            #1;
            check("beat_owner_grant", 32'(to_i ? icache_grant : dcache_grant), 32'd1);
            check("beat_other_grant", 32'(to_i ? dcache_grant : icache_grant), 32'd0);
            check("beat_owner_valid", 32'(to_i ? icache_MemDataValid : dcache_MemDataValid), 32'd1);
            check("beat_owner_data", 32'(to_i ? icache_read_data : dcache_read_data), 32'(base + k));
            check("beat_other_valid", 32'(to_i ? dcache_MemDataValid : icache_MemDataValid), 32'd0);
            tick();
        end
        MemDataValid  = 1'b0;
        mem_read_data = '0;
    endtask

    task automatic check_idle(input string name);
        #1;
        check({name, "_igrant"}, 32'(icache_grant), 32'd0);
        check({name, "_dgrant"}, 32'(dcache_grant), 32'd0);
        check({name, "_rd"}, 32'(mem_MemRead), 32'd0);
        check({name, "_wr"}, 32'(mem_MemWrite), 32'd0);
    endtask

    task automatic clear_inputs();
        icache_MemRead        = 1'b0;
        icache_mem_addr       = '0;
        dcache_MemRead        = 1'b0;
        dcache_MemWrite       = 1'b0;
        dcache_mem_addr       = '0;
        dcache_mem_write_data = '0;
        MemDataValid          = 1'b0;
        mem_read_data         = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        repeat (2) tick();
        check_idle("reset");
        rst = 1'b1;
        tick();

        // Reset mid I-fill after three beats.
        icache_MemRead  = 1'b1;
        icache_mem_addr = 16'h0040;
        tick();
        check("rst_test_addr", 32'(mem_addr), 32'h0040);
        do_beats(1'b1, 3, 16'h0010);
        MemDataValid  = 1'b1;
        mem_read_data = 16'h0099;
        rst = 1'b0;
        #1;
        check("rst_async_igrant", 32'(icache_grant), 32'd0);
        check("rst_async_rd", 32'(mem_MemRead), 32'd0);
        check("rst_async_ivalid", 32'(icache_MemDataValid), 32'd0);
        check("rst_async_addr", 32'(mem_addr), 32'd0);
        tick();
        rst          = 1'b1;
        MemDataValid = 1'b0;
        tick();
        do_beats(1'b1, 7, 16'h0020);
        #1;
        check("rst_refill_held_after7", 32'(icache_grant), 32'd1);
        do_beats(1'b1, 1, 16'h0027);
        icache_MemRead = 1'b0;
        check_idle("rst_refill_done");

        // Single I fill, memory latency of four cycles.
        icache_MemRead  = 1'b1;
        icache_mem_addr = 16'h0000;
        tick();
        check("ifill_grant", 32'(icache_grant), 32'd1);
        check("ifill_memread", 32'(mem_MemRead), 32'd1);
        repeat (4) begin
            tick();
            check("ifill_wait_grant", 32'(icache_grant), 32'd1);
        end
        do_beats(1'b1, 8, 1);
        icache_MemRead = 1'b0;
        check_idle("ifill_done");

        // Tie from reset: D first, then I, then D again.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        icache_MemRead = 1'b1;
        dcache_MemRead = 1'b1;
        dcache_mem_addr = 16'h0100;
        tick();
        check("tie1_dgrant", 32'(dcache_grant), 32'd1);
        check("tie1_igrant", 32'(icache_grant), 32'd0);
        do_beats(1'b0, 8, 16'h0100);
        dcache_MemRead = 1'b0;
        check_idle("tie1_gap");
        tick();
        check("tie1_then_i", 32'(icache_grant), 32'd1);
        do_beats(1'b1, 8, 16'h0200);
        icache_MemRead = 1'b0;
        tick();
        icache_MemRead = 1'b1;
        dcache_MemRead = 1'b1;
        tick();
        check("tie2_dgrant", 32'(dcache_grant), 32'd1);
        do_beats(1'b0, 8, 16'h0300);
        dcache_MemRead = 1'b0;
        icache_MemRead = 1'b0;
        tick();

        // Single D write.
        dcache_MemWrite       = 1'b1;
        dcache_mem_addr       = 16'h0010;
        dcache_mem_write_data = 16'hBEEF;
        tick();
        check("dwr_memwrite", 32'(mem_MemWrite), 32'd1);
        check("dwr_addr", 32'(mem_addr), 32'h0010);
        check("dwr_data", 32'(mem_write_data), 32'hBEEF);
        check("dwr_grant", 32'(dcache_grant), 32'd1);
        tick();
        check("dwr_one_cycle", 32'(mem_MemWrite), 32'd0);
        check("dwr_wdata_zero", 32'(mem_write_data), 32'd0);
        dcache_MemWrite = 1'b0;
        tick();

        // D write raised during an I fill waits for the final beat.
        icache_MemRead = 1'b1;
        tick();
        do_beats(1'b1, 2, 16'h0400);
        dcache_MemWrite       = 1'b1;
        dcache_mem_addr       = 16'h0020;
        dcache_mem_write_data = 16'h5A5A;
        do_beats(1'b1, 6, 16'h0402);
        icache_MemRead = 1'b0;
        check_idle("wr_wait_gap");
        tick();
        check("wr_after_fill", 32'(mem_MemWrite), 32'd1);
        check("wr_after_fill_addr", 32'(mem_addr), 32'h0020);
        dcache_MemWrite = 1'b0;
        tick();

        // Stray valid while idle.
        MemDataValid  = 1'b1;
        mem_read_data = 16'h1234;
        repeat (2) begin
            #1;
            check("stray_ivalid", 32'(icache_MemDataValid), 32'd0);
            check("stray_dvalid", 32'(dcache_MemDataValid), 32'd0);
            check("stray_idata", 32'(icache_read_data), 32'd0);
            tick();
        end
        MemDataValid   = 1'b0;
        icache_MemRead = 1'b1;
        tick();
        do_beats(1'b1, 7, 16'h0500);
        #1;
        check("stray_fill_held", 32'(icache_grant), 32'd1);
        do_beats(1'b1, 1, 16'h0507);
        icache_MemRead = 1'b0;
        check_idle("stray_fill_done");

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst                   = ($urandom_range(0, 299) != 0);
            icache_MemRead        = ($urandom_range(0, 2) != 0);
            icache_mem_addr       = ADDR_W'($urandom);
            dcache_MemRead        = ($urandom_range(0, 2) == 0);
            dcache_MemWrite       = ($urandom_range(0, 3) == 0);
            dcache_mem_addr       = ADDR_W'($urandom);
            dcache_mem_write_data = DATA_W'($urandom);
            MemDataValid          = ($urandom_range(0, 4) < 3);
            mem_read_data         = DATA_W'($urandom);
            tick();
        end
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
